dut_8bit_addr_arb: RTL and testbench
====================================

// Module: dut_8bit_addr_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one dut_8bit_addr instance among NUM_REQ requesters.
//  Accepts one operand pair at a time and issues it to the adder with a one-cycle Data_val pulse.
//  Waits for Data_ready and returns sum/carry tagged with the requester id.
//  A watchdog recovers from an adder that never answers.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  IDX_W    2   width of requester index, = clog2(NUM_REQ)
//  TIMEOUT  15  max cycles in WAIT before aborting (1..255)
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          synchronous, active-high
//  req_valid    in   NUM_REQ    per-requester request
//  req_a        in   8*NUM_REQ  operand A, requester i at [8i+7:8i]
//  req_b        in   8*NUM_REQ  operand B, same packing
//  req_ready    out  NUM_REQ    one-hot accept pulse, operands latched this cycle
//  rsp_valid    out  1          one-cycle response strobe
//  rsp_id       out  IDX_W      requester index of response
//  rsp_sum      out  8          Sum_result captured from adder
//  rsp_carry    out  1          Sum_carry captured from adder
//  rsp_timeout  out  1          response is a watchdog abort
//  busy         out  1          high in any state except IDLE
//  Value_a      out  8          to adder operand A
//  Value_b      out  8          to adder operand B
//  Data_val     out  1          to adder, operand-valid pulse
//  Sum_result   in   8          from adder
//  Sum_carry    in   1          from adder
//  Data_ready   in   1          from adder, result valid
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; ptr=NUM_REQ-1 (requester 0 wins first); timer=0.
//  Reset mid-operation abandons the transaction: no rsp_valid, operands dropped.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE, one state per cycle except WAIT.
//  IDLE: req_valid sampled only here. If any bit set, grant first set bit searching
//   ptr+1, ptr+2, ... modulo NUM_REQ. Same cycle: req_ready[g]=1 (combinational on
//   req_valid), latch req_a/req_b slice g and id g. Next state ISSUE. No request: stay.
//  ISSUE: Value_a/Value_b = latched operands, Data_val=1 for exactly this cycle;
//   timer cleared. Data_ready ignored this cycle. -> WAIT.
//  WAIT: Data_val=0; Value_a/Value_b held stable. Data_ready=1: capture Sum_result,
//   Sum_carry into rsp_sum/rsp_carry, rsp_timeout=0 -> RESP. Else timer+1;
//   timer==TIMEOUT with no Data_ready: rsp_sum=0, rsp_carry=0, rsp_timeout=1 -> RESP.
//   Data_ready and timeout in the same cycle: Data_ready wins.
//  RESP: rsp_valid=1 one cycle with rsp_id; ptr<=rsp_id; -> IDLE. No backpressure.
//   rsp_sum/rsp_carry/rsp_id/rsp_timeout hold until next RESP; Value_a/Value_b
//   return to 0 in IDLE.
//  Arithmetic: no computation here; 9-bit result = {rsp_carry,rsp_sum} from adder.
//  Latency: accept -> rsp_valid = 3 cycles when Data_ready is high on first WAIT cycle.
//   Peak throughput one op per 4 cycles.
//  Fairness: requester granted in cycle N is lowest priority at next arbitration;
//   any continuously requesting requester is served within NUM_REQ transactions.
//  ptr wraps NUM_REQ-1 -> 0. req_valid withdrawn before IDLE sampling: no grant.
//  req_ready never asserted outside IDLE; at most one bit high.
// TESTING
//  1 req_valid=0001, a0=0x0F, b0=0x01 -> req_ready=0001 1 cycle; Data_val 1 cycle with
//    0x0F/0x01; rsp_valid, rsp_id=0, rsp_sum=0x10, rsp_carry=0, 3 cycles after accept.
//  2 req2: 0xFF+0x01 -> rsp_id=2, rsp_sum=0x00, rsp_carry=1; 0xFF+0xFF -> 0xFE, carry 1.
//  3 req_valid=1111 held, distinct operands -> grants 0,1,2,3,0,1; each response id and
//    sum match its own operands (0xAA+0x55 -> 0xFF, carry 0).
//  4 adder model Data_ready tied 0 -> rsp_valid after TIMEOUT WAIT cycles, rsp_timeout=1,
//    sum=0, carry=0; next request completes normally.
//  5 reset asserted 1 cycle during WAIT -> next cycle all outputs 0, busy=0, no rsp_valid;
//    req_valid=1111 then grants requester 0.
//  6 req_valid=0100 then 0110 after response -> second grant to 1 after ptr=2 wrap search
//    (order 3,0,1): confirms ptr update and wrap.

Source files
------------

// File: rtl/dut_8bit_addr_arb.sv
// Round-robin sequencer that shares one 8-bit adder among NUM_REQ requesters.
// Operands are issued with a one-cycle Data_val pulse; a watchdog aborts a silent adder.
module dut_8bit_addr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   output logic [IDX_W-1:0]       rsp_id,
   output logic [7:0]             rsp_sum,
   output logic                   rsp_carry,
   output logic                   rsp_timeout,
   output logic                   busy,
   output logic [7:0]             Value_a,
   output logic [7:0]             Value_b,
   output logic                   Data_val,
   input  logic [7:0]             Sum_result,
   input  logic                   Sum_carry,
   input  logic                   Data_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Last WAIT cycle index: timer counts completed WAIT cycles from 0.
   localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(NUM_REQ - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] id_q, id_d;
   logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
   logic [7:0]       op_a_q, op_a_d;
   logic [7:0]       op_b_q, op_b_d;
   logic [7:0]       rsp_sum_q, rsp_sum_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic [7:0]       timer_q, timer_d;

   logic [NUM_REQ-1:0] upper_mask_s;
   logic [NUM_REQ-1:0] masked_req_s;
   logic               grant_any_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic [NUM_REQ-1:0] grant_onehot_s;

   // Round-robin pick: lowest request above ptr, else lowest request overall.
   always_comb begin
      upper_mask_s   = '0;
      grant_idx_s    = '0;
      grant_onehot_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask_s[i] = (IDX_W'(i) > ptr_q);
      end
      masked_req_s = req_valid & upper_mask_s;
      grant_any_s  = |req_valid;
      if (|masked_req_s) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            grant_idx_s = masked_req_s[i] ? IDX_W'(i) : grant_idx_s;
         end
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            grant_idx_s = req_valid[i] ? IDX_W'(i) : grant_idx_s;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_onehot_s[i] = grant_any_s && (grant_idx_s == IDX_W'(i));
      end
   end

   // Next-state and datapath capture for the IDLE->ISSUE->WAIT->RESP sequence.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      id_d          = id_q;
      rsp_id_d      = rsp_id_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_sum_d     = rsp_sum_q;
      rsp_carry_d   = rsp_carry_q;
      rsp_timeout_d = rsp_timeout_q;
      timer_d       = timer_q;
      req_ready     = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant_any_s) begin
               req_ready = grant_onehot_s;
               id_d      = grant_idx_s;
               op_a_d    = req_a[8*int'(grant_idx_s) +: 8];
               op_b_d    = req_b[8*int'(grant_idx_s) +: 8];
               state_d   = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            timer_d = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (Data_ready) begin
               rsp_sum_d     = Sum_result;
               rsp_carry_d   = Sum_carry;
               rsp_timeout_d = 1'b0;
               rsp_id_d      = id_q;
               state_d       = ST_RESP;
            end else if (timer_q == TIMER_LAST) begin
               rsp_sum_d     = 8'd0;
               rsp_carry_d   = 1'b0;
               rsp_timeout_d = 1'b1;
               rsp_id_d      = id_q;
               state_d       = ST_RESP;
            end else begin
               timer_d = timer_q + 8'd1;
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            ptr_d   = rsp_id_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= PTR_RESET;
         id_q          <= '0;
         rsp_id_q      <= '0;
         op_a_q        <= 8'd0;
         op_b_q        <= 8'd0;
         rsp_sum_q     <= 8'd0;
         rsp_carry_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         timer_q       <= 8'd0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         id_q          <= id_d;
         rsp_id_q      <= rsp_id_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         rsp_sum_q     <= rsp_sum_d;
         rsp_carry_q   <= rsp_carry_d;
         rsp_timeout_q <= rsp_timeout_d;
         timer_q       <= timer_d;
      end
   end

   // Outputs decoded from registered state only; operands hold through WAIT and RESP.
   always_comb begin
      rsp_valid   = (state_q == ST_RESP);
      busy        = (state_q != ST_IDLE);
      Data_val    = (state_q == ST_ISSUE);
      Value_a     = (state_q == ST_IDLE) ? 8'd0 : op_a_q;
      Value_b     = (state_q == ST_IDLE) ? 8'd0 : op_b_q;
      rsp_id      = rsp_id_q;
      rsp_sum     = rsp_sum_q;
      rsp_carry   = rsp_carry_q;
      rsp_timeout = rsp_timeout_q;
   end

endmodule

// File: tb/tb_dut_8bit_addr_arb.sv
// Directed plus randomized bench for dut_8bit_addr_arb with a latency-programmable adder model
// and a transaction-level round-robin reference.
module tb_dut_8bit_addr_arb;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int TIMEOUT = 15;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic [IDX_W-1:0]     rsp_id;
   logic [7:0]           rsp_sum;
   logic                 rsp_carry;
   logic                 rsp_timeout;
   logic                 busy;
   logic [7:0]           Value_a;
   logic [7:0]           Value_b;
   logic                 Data_val;
   logic [7:0]           Sum_result;
   logic                 Sum_carry;
   logic                 Data_ready;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [7:0] op_a [NUM_REQ];
   logic [7:0] op_b [NUM_REQ];
   int         mptr;
   int         adder_lat;
   logic [8:0] add_res;
   int         add_cnt;

   dut_8bit_addr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_carry(rsp_carry), .rsp_timeout(rsp_timeout), .busy(busy), .Value_a(Value_a),
      .Value_b(Value_b), .Data_val(Data_val), .Sum_result(Sum_result),
      .Sum_carry(Sum_carry), .Data_ready(Data_ready)
   );

   always #5 clk = ~clk;

   // Adder model: answers adder_lat cycles after Data_val; adder_lat of 0 never answers.
   always @(posedge clk) begin
      if (reset) begin
         add_cnt <= 0;
      end else if (Data_val) begin
         add_res <= {1'b0, Value_a} + {1'b0, Value_b};
         add_cnt <= adder_lat;
      end else if (add_cnt != 0) begin
         add_cnt <= add_cnt - 1;
      end
   end
   assign Data_ready = (add_cnt == 1);
   assign Sum_result = add_res[7:0];
   assign Sum_carry  = add_res[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      op_a[i] = a;
      op_b[i] = b;
      req_a[8*i +: 8] = a;
      req_b[8*i +: 8] = b;
   endtask

   // Reference arbitration: first requester after the last one served, modulo NUM_REQ.
   function automatic int model_grant(input logic [NUM_REQ-1:0] m);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (m[(mptr + k) % NUM_REQ]) return (mptr + k) % NUM_REQ;
      end
      return 0;
   endfunction

   task automatic run_txn(input logic [NUM_REQ-1:0] vmask, input int lat, input bit keep,
                          output int g);
      int         e;
      int         k;
      bit         to;
      bit         got;
      logic [8:0] s;
      logic [NUM_REQ-1:0] exp_rdy;
      g  = model_grant(vmask);
      to = (lat == 0) || (lat > TIMEOUT);
      e  = to ? TIMEOUT : lat;
      s  = {1'b0, op_a[g]} + {1'b0, op_b[g]};
      exp_rdy    = '0;
      exp_rdy[g] = 1'b1;
      adder_lat  = lat;
      @(negedge clk);
      req_valid = vmask;
      #1;
      chk("accept_ready", 16'(req_ready), 16'(exp_rdy));
      chk("accept_busy", 16'(busy), 16'd0);
      @(posedge clk); #1;
      if (!keep) req_valid = '0;
      chk("issue_dval", 16'(Data_val), 16'd1);
      chk("issue_va", 16'(Value_a), 16'(op_a[g]));
      chk("issue_vb", 16'(Value_b), 16'(op_b[g]));
      chk("issue_ready", 16'(req_ready), 16'd0);
      got = 1'b0;
      k   = 0;
      while (!got && k < TIMEOUT + 4) begin
         @(posedge clk); #1;
         k++;
         if (rsp_valid) begin
            got = 1'b1;
         end else begin
            chk("wait_dval", 16'(Data_val), 16'd0);
            chk("wait_va", 16'(Value_a), 16'(op_a[g]));
            chk("wait_ready", 16'(req_ready), 16'd0);
         end
      end
      chk("rsp_latency", 16'(k), 16'(1 + e));
      chk("rsp_id", 16'(rsp_id), 16'(g));
      chk("rsp_sum", 16'(rsp_sum), to ? 16'd0 : 16'(s[7:0]));
      chk("rsp_carry", 16'(rsp_carry), to ? 16'd0 : 16'(s[8]));
      chk("rsp_timeout", 16'(rsp_timeout), 16'(to));
      chk("rsp_busy", 16'(busy), 16'd1);
      mptr = g;
      @(posedge clk); #1;
      chk("idle_rsp_valid", 16'(rsp_valid), 16'd0);
      chk("idle_busy", 16'(busy), 16'd0);
      chk("idle_va", 16'(Value_a), 16'd0);
      chk("idle_hold_id", 16'(rsp_id), 16'(g));
      chk("idle_hold_sum", 16'(rsp_sum), to ? 16'd0 : 16'(s[7:0]));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 16'(busy), 16'd0);
      chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
      chk({tag, "_dval"}, 16'(Data_val), 16'd0);
      chk({tag, "_va"}, 16'(Value_a), 16'd0);
      chk({tag, "_vb"}, 16'(Value_b), 16'd0);
      chk({tag, "_ready"}, 16'(req_ready), 16'd0);
      chk({tag, "_id"}, 16'(rsp_id), 16'd0);
      chk({tag, "_sum"}, 16'(rsp_sum), 16'd0);
      chk({tag, "_carry"}, 16'(rsp_carry), 16'd0);
      chk({tag, "_timeout"}, 16'(rsp_timeout), 16'd0);
   endtask

   initial begin
      int g;
      int rr_exp [6];
      int lat_tab [7];
      rr_exp  = '{0, 1, 2, 3, 0, 1};
      lat_tab = '{1, 2, 3, 5, TIMEOUT, TIMEOUT + 1, 0};
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      adder_lat = 1;
      for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'd0, 8'd0);
      mptr = NUM_REQ - 1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // All requesting: round robin starting at requester 0.
      set_op(0, 8'h11, 8'h22);
      set_op(1, 8'h33, 8'h44);
      set_op(2, 8'h80, 8'h90);
      set_op(3, 8'hAA, 8'h55);
      for (int n = 0; n < 6; n++) begin
         run_txn(4'b1111, 1, 1'b1, g);
         chk("rr_order", 16'(g), 16'(rr_exp[n]));
      end
      req_valid = '0;

      // Single requester 0, minimum latency.
      set_op(0, 8'h0F, 8'h01);
      run_txn(4'b0001, 1, 1'b0, g);

      // No request: stays idle, nothing granted.
      repeat (3) begin
         @(negedge clk);
         chk("nogrant_busy", 16'(busy), 16'd0);
         chk("nogrant_ready", 16'(req_ready), 16'd0);
      end

      // Carry out from requester 2.
      set_op(2, 8'hFF, 8'h01);
      run_txn(4'b0100, 1, 1'b0, g);
      set_op(2, 8'hFF, 8'hFF);
      run_txn(4'b0100, 2, 1'b0, g);

      // Watchdog: silent adder, then normal recovery, then both boundary latencies.
      set_op(1, 8'h12, 8'h34);
      run_txn(4'b0010, 0, 1'b0, g);
      run_txn(4'b0010, 1, 1'b0, g);
      run_txn(4'b0010, TIMEOUT, 1'b0, g);
      run_txn(4'b0010, TIMEOUT + 1, 1'b0, g);

      // Wrap search from ptr=2: 0100 then 0110 grants 2 then 1.
      run_txn(4'b0100, 1, 1'b0, g);
      chk("wrap_first", 16'(g), 16'd2);
      run_txn(4'b0110, 1, 1'b0, g);
      chk("wrap_second", 16'(g), 16'd1);

      // Reset while waiting on a silent adder abandons the transaction.
      adder_lat = 0;
      @(negedge clk);
      req_valid = 4'b0001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 16'(busy), 16'd1);
      req_valid = '0;
      reset     = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      mptr  = NUM_REQ - 1;
      repeat (4) begin
         @(negedge clk);
         chk("post_reset_no_rsp", 16'(rsp_valid), 16'd0);
      end
      run_txn(4'b1111, 1, 1'b0, g);
      chk("post_reset_grant", 16'(g), 16'd0);

      // Randomized traffic against the reference.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         end
         run_txn(4'($urandom_range(1, 15)), lat_tab[$urandom_range(0, 6)],
                 1'($urandom_range(0, 1)), g);
      end
      req_valid = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
